// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//
// Parametrised controller for an asynchronous SRAM. A host issues single read
// or write requests over a req/ready handshake; the controller sequences the
// active-low SRAM strobes, the registered address and the bidirectional data
// bus with a configurable strobe width (ACCESS_CYC) and a configurable idle
// turnaround (TURN_CYC) whenever the bus direction changes between
// transactions.
//
// Optional feature macro: SRAM_CTRL_BURST_EN
//   Defined   : a transaction is burst_len+1 beats at incrementing addresses.
//               The address wraps modulo 2^ADDR_W. Write data for each later
//               beat is taken from wdata at the edge that ends the previous
//               beat's HOLD cycle.
//   Undefined : every transaction is a single beat and burst_len is ignored.
//
// Parameters
//   ADDR_W     address width
//   DATA_W     data width
//   ACCESS_CYC cycles we/oe are held asserted per beat (>= 1)
//   TURN_CYC   idle cycles inserted on a direction change (>= 0)
//
// Ports
//   clk        clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   req        transaction request, accepted when req && ready at a clock edge
//   wr         1 = write, 0 = read, sampled with req
//   addr       start address, sampled with req
//   wdata      write data (first beat sampled with req)
//   burst_len  beats-1, used only with SRAM_CTRL_BURST_EN
//   ready      high only while idle (combinational state decode)
//   rvalid     one-cycle pulse per read beat
//   rdata      read data, valid while rvalid, held otherwise
//   beat       one-cycle pulse per completed beat
//   cs, we, oe SRAM strobes, active-low, registered
//   address    SRAM address, registered
//   data       SRAM data bus, driven only while cs=0 during a write
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned ACCESS_CYC = 2,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        burst_len,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              beat,
    output logic              cs,
    output logic              we,
    output logic              oe,
    output logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data
);

    // One down-counter serves both TURN and ACCESS; size it for the longer.
    localparam int unsigned CntMax = (ACCESS_CYC > TURN_CYC) ? ACCESS_CYC : TURN_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] AccessLoad = CntW'((ACCESS_CYC > 0) ? ACCESS_CYC - 1 : 0);
    localparam logic [CntW-1:0] TurnLoad   = CntW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StTurn,
        StSetup,
        StAccess,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;   // direction of the transaction in flight
    logic              dir_q, dir_d;       // direction of the last completed beat
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Registered output strobes, computed from the next state so that every
    // SRAM-facing output comes straight from a flop.
    logic cs_q, cs_d;
    logic we_q, we_d;
    logic oe_q, oe_d;
    logic drive_q, drive_d;
    logic beat_q, beat_d;
    logic rvalid_q, rvalid_d;
    logic strobe_on;

`ifdef SRAM_CTRL_BURST_EN
    logic [3:0] beats_q, beats_d;          // beats remaining after the current one
`else
    logic unused_burst_len;
    assign unused_burst_len = ^burst_len;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        dir_d     = dir_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
`ifdef SRAM_CTRL_BURST_EN
        beats_d   = beats_q;
`endif

        case (state_q)
            StIdle: begin
                if (req) begin
                    op_wr_d   = wr;
                    address_d = addr;
                    wdata_d   = wdata;
`ifdef SRAM_CTRL_BURST_EN
                    beats_d   = burst_len;
`endif
                    if ((TURN_CYC != 0) && (wr != dir_q)) begin
                        state_d = StTurn;
                        cnt_d   = TurnLoad;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end

            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StSetup;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            StSetup: begin
                state_d = StAccess;
                cnt_d   = AccessLoad;
            end

            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    // Sample the bus at the edge that ends the last strobe cycle.
                    if (!op_wr_q) begin
                        rdata_d = data;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            StHold: begin
                dir_d = op_wr_q;
`ifdef SRAM_CTRL_BURST_EN
                if (beats_q != 4'd0) begin
                    // Next beat re-enters ACCESS directly; cs stays low.
                    beats_d   = beats_q - 4'd1;
                    address_d = address_q + 1'b1;
                    wdata_d   = wdata;
                    state_d   = StAccess;
                    cnt_d     = AccessLoad;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next output values, decoded from the next state
    // -------------------------------------------------------------------------
    always_comb begin
        strobe_on = (state_d == StSetup) || (state_d == StAccess) || (state_d == StHold);
        cs_d      = !strobe_on;
        we_d      = !((state_d == StAccess) && op_wr_d);
        oe_d      = !((state_d == StAccess) && !op_wr_d);
        drive_d   = strobe_on && op_wr_d;
        beat_d    = (state_d == StHold);
        rvalid_d  = (state_d == StHold) && !op_wr_d;
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            dir_q     <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cs_q      <= 1'b1;
            we_q      <= 1'b1;
            oe_q      <= 1'b1;
            drive_q   <= 1'b0;
            beat_q    <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            dir_q     <= dir_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
            drive_q   <= drive_d;
            beat_q    <= beat_d;
            rvalid_q  <= rvalid_d;
        end
    end

`ifdef SRAM_CTRL_BURST_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beats_q <= 4'd0;
        end else begin
            beats_q <= beats_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ready   = (state_q == StIdle);
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign beat    = beat_q;
    assign cs      = cs_q;
    assign we      = we_q;
    assign oe      = oe_q;
    assign address = address_q;
    assign data    = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//
// Self-checking bench for sram_ctrl with default parameters. A small SRAM
// model sits on the bus; a transaction-level reference (ref_mem, last_dir)
// predicts read data and turnaround, and per-cycle expectations are derived
// from the documented cycle timeline of a transaction. The data bus is a
// pulled-up net, so an undriven bus reads as all ones.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 4;
    localparam int unsigned AC = 2;
    localparam int unsigned TC = 1;
    localparam logic [DW-1:0] BusIdle = '1;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          req       = 1'b0;
    logic          wr        = 1'b0;
    logic [AW-1:0] addr      = '0;
    logic [DW-1:0] wdata     = '0;
    logic [3:0]    burst_len = '0;
    logic          ready, rvalid, beat, cs, we, oe;
    logic [DW-1:0] rdata;
    logic [AW-1:0] address;
    tri1  [DW-1:0] data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [0:255];   // SRAM device model
    logic [DW-1:0] ref_mem [0:255];   // expected memory contents
    bit            last_dir;          // direction of last completed op (1 = write)

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            turn;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vecs [8];

    sram_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ACCESS_CYC(AC),
        .TURN_CYC  (TC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .burst_len(burst_len),
        .ready    (ready),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .beat     (beat),
        .cs       (cs),
        .we       (we),
        .oe       (oe),
        .address  (address),
        .data     (data)
    );

    always #5 clk = ~clk;

    // SRAM model: drives while selected for read, stores on a write strobe.
    assign data = (!cs && !oe) ? mem[address] : {DW{1'bz}};

    always @(posedge clk) begin
        if (reset && !cs && !we) begin
            mem[address] <= data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 32'(ready), 32'd1);
    endtask

    // One single-beat transaction with cycle-by-cycle checks. Cycle k counts
    // from the accepting edge: TURN 1..t, SETUP t+1, ACCESS t+2..t+1+AC,
    // HOLD t+2+AC, idle/ready t+3+AC.
    task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit exp_turn, input logic [DW-1:0] exp_rd);
        int    t, lat;
        bit    setup, acc, hold, on;
        string tag;
        wait_ready();
        req       = 1'b1;
        wr        = w;
        addr      = a;
        wdata     = d;
        burst_len = 4'd0;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the controller must have latched them.
        req       = 1'b0;
        wr        = 1'($urandom);
        addr      = AW'($urandom);
        wdata     = DW'($urandom);
        burst_len = 4'($urandom);
        t   = exp_turn ? int'(TC) : 0;
        lat = t + 3 + int'(AC);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            setup = (k == t + 1);
            acc   = (k >= t + 2) && (k <= t + 1 + int'(AC));
            hold  = (k == t + 2 + int'(AC));
            on    = setup || acc || hold;
            tag   = $sformatf("%s@%02h c%0d", w ? "wr" : "rd", a, k);
            chk({tag, " cs"},     32'(cs),     32'(!on));
            chk({tag, " we"},     32'(we),     32'(!(acc && w)));
            chk({tag, " oe"},     32'(oe),     32'(!(acc && !w)));
            chk({tag, " beat"},   32'(beat),   32'(hold));
            chk({tag, " rvalid"}, 32'(rvalid), 32'(hold && !w));
            chk({tag, " ready"},  32'(ready),  32'(k == lat));
            if (on) begin
                chk({tag, " address"}, 32'(address), 32'(a));
            end
            if (oe) begin
                chk({tag, " data"}, 32'(data), 32'((on && w) ? d : BusIdle));
            end
            if (!w && (hold || k == lat)) begin
                chk({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
            end
        end
        if (w) begin
            ref_mem[a] = d;
        end
        last_dir = w;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " cs"},      32'(cs),      32'd1);
        chk({tag, " we"},      32'(we),      32'd1);
        chk({tag, " oe"},      32'(oe),      32'd1);
        chk({tag, " data"},    32'(data),    32'(BusIdle));
        chk({tag, " ready"},   32'(ready),   32'd1);
        chk({tag, " rvalid"},  32'(rvalid),  32'd0);
        chk({tag, " beat"},    32'(beat),    32'd0);
        chk({tag, " address"}, 32'(address), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        bit            rw;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i) ^ 4'h5;
            ref_mem[i] = DW'(i) ^ 4'h5;
        end
        last_dir = 1'b0;

        // {wr, addr, wdata, expect turnaround, expected rdata}
        vecs[0] = '{1'b1, 8'h3C, 4'hA, 1'b1, 4'h0};
        vecs[1] = '{1'b0, 8'h3C, 4'h0, 1'b1, 4'hA};
        vecs[2] = '{1'b0, 8'h10, 4'h0, 1'b0, 4'h5};
        vecs[3] = '{1'b0, 8'h11, 4'h0, 1'b0, 4'h4};
        vecs[4] = '{1'b1, 8'hFF, 4'h3, 1'b1, 4'h0};
        vecs[5] = '{1'b1, 8'h00, 4'hC, 1'b0, 4'h0};
        vecs[6] = '{1'b0, 8'hFF, 4'h0, 1'b1, 4'h3};
        vecs[7] = '{1'b0, 8'h00, 4'h0, 1'b0, 4'hC};

        // Power-on reset, then reset asserted again while idle.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_idle_outputs("reset_idle");
        chk("reset_idle rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven directed transactions.
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].turn, vecs[i].rd);
        end

        // Reset during the first ACCESS cycle of a write (last op was a read,
        // so cycle 1 is TURN, cycle 2 SETUP, cycle 3 ACCESS).
        wait_ready();
        req   = 1'b1;
        wr    = 1'b1;
        addr  = 8'h80;
        wdata = 4'h6;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort pre we", 32'(we), 32'd0);
        chk("abort pre data", 32'(data), 32'h6);
        #1 reset = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_abort c%0d beat", k), 32'(beat), 32'd0);
            chk($sformatf("post_abort c%0d cs", k), 32'(cs), 32'd1);
            chk($sformatf("post_abort c%0d ready", k), 32'(ready), 32'd1);
        end
        last_dir = 1'b0;

        // Randomised traffic in a small address window against the reference.
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 8'h20 | AW'($urandom_range(0, 15));
            rd = DW'($urandom);
            do_txn(rw, ra, rd, (rw != last_dir) && (TC != 0), ref_mem[ra]);
        end

`ifdef SRAM_CTRL_BURST_EN
        begin
            int t, nb, span;
            wait_ready();
            t     = (last_dir != 1'b1 && TC != 0) ? int'(TC) : 0;
            span  = 1 + 4 * (int'(AC) + 1);
            nb    = 0;
            req       = 1'b1;
            wr        = 1'b1;
            addr      = 8'hFE;
            wdata     = 4'd1;
            burst_len = 4'd3;
            @(posedge clk);
            #1 req = 1'b0;
            for (int k = 1; k <= t + span + 1; k++) begin
                @(negedge clk);
                chk($sformatf("burst c%0d cs", k), 32'(cs), 32'(!(k > t && k <= t + span)));
                if (beat) begin
                    chk($sformatf("burst beat%0d address", nb), 32'(address),
                        32'(AW'(8'hFE + nb)));
                    nb++;
                    wdata = DW'(nb + 1);
                end
            end
            chk("burst beat count", 32'(nb), 32'd4);
            chk("burst end ready", 32'(ready), 32'd1);
            ref_mem[8'hFE] = 4'd1;
            ref_mem[8'hFF] = 4'd2;
            ref_mem[8'h00] = 4'd3;
            ref_mem[8'h01] = 4'd4;
            last_dir = 1'b1;
            do_txn(1'b0, 8'hFE, 4'h0, 1'b1, ref_mem[8'hFE]);
            do_txn(1'b0, 8'hFF, 4'h0, 1'b0, ref_mem[8'hFF]);
            do_txn(1'b0, 8'h00, 4'h0, 1'b0, ref_mem[8'h00]);
            do_txn(1'b0, 8'h01, 4'h0, 1'b0, ref_mem[8'h01]);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised asynchronous-SRAM controller; next generation of the fixed 8-bit-address / 4-bit-data memory FSM. Accepts single read/write requests from a host over a req/ready handshake and drives the SRAM strobes, address and bidirectional data bus. Timing is configurable: strobe width, direction-change turnaround and, optionally, incrementing bursts. Sits between the host logic and the SRAM model/pins at the top level.

## Interface
- ADDR_W, 8, address width
- DATA_W, 4, data width
- ACCESS_CYC, 2, cycles we/oe held asserted per beat (>=1)
- TURN_CYC, 1, idle cycles inserted when direction changes (>=0)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  transaction request; accepted when req&&ready at clk edge
- wr  in  1  1=write, 0=read; sampled with req
- addr  in  ADDR_W  start address; sampled with req
- wdata  in  DATA_W  write data; see beat rules
- burst_len  in  4  beats-1; used only with SRAM_CTRL_BURST_EN
- ready  out  1  high only in IDLE
- rvalid  out  1  one-cycle pulse per read beat
- rdata  out  DATA_W  read data, valid while rvalid, held otherwise
- beat  out  1  one-cycle pulse per completed beat (read or write)
- cs, we, oe  out  1 each  SRAM strobes, active-low
- address  out  ADDR_W  SRAM address, registered
- data  inout  DATA_W  SRAM data; driven only while cs=0 and current op is write, else high-Z

## Operation
- States: IDLE, TURN, SETUP, ACCESS, HOLD.
- IDLE: cs=we=oe=1, bus high-Z, ready=1. On accept: latch wr, addr, wdata, burst_len; go TURN if wr differs from last completed op's direction and TURN_CYC>0, else SETUP. Direction register resets to read.
- TURN: TURN_CYC cycles, all strobes inactive, bus high-Z, then SETUP.
- SETUP: 1 cycle; cs=0, address valid, we=oe=1, write data driven.
- ACCESS: ACCESS_CYC cycles; cs=0 and we=0 (write) or oe=0 (read). Read data captured into rdata at the edge ending the last ACCESS cycle.
- HOLD: 1 cycle; cs=0, we=oe=1, address and write data held; beat=1; rvalid=1 for reads. Then IDLE, or next beat (burst).
- Address arithmetic is modulo 2^ADDR_W (wraps max->0).
- req while not ready is ignored (not queued); host must hold req.
- Reset mid-transaction: immediate abort, strobes inactive, bus released, no rvalid/beat.

## Timing
- Reset values: cs=we=oe=1, address=0, data high-Z, rdata=0, rvalid=0, beat=0, ready=1, state IDLE.
- Accept at edge E (cycle 0); no turnaround: SETUP cycle 1, ACCESS cycles 2..1+ACCESS_CYC, HOLD cycle 2+ACCESS_CYC, ready=1 cycle 3+ACCESS_CYC. Turnaround adds TURN_CYC cycles before SETUP.
- Back-to-back same-direction requests: 3+ACCESS_CYC cycles per transaction.
- All outputs registered; no combinational path from inputs to outputs except ready (state decode).

## Configuration
- SRAM_CTRL_BURST_EN defined: transaction is burst_len+1 beats. After each non-final HOLD, address increments by 1 and the FSM returns to ACCESS (SETUP not repeated, cs stays 0). Write data for beat k>0 is sampled from wdata at the edge ending the HOLD of beat k-1; host updates wdata while beat=1. Turnaround only at transaction start.
- Undefined: burst_len ignored, every transaction is one beat; no burst counter logic synthesised.

## Test plan
- Assert reset low mid-idle -> cs=we=oe=1, data Z, ready=1, rvalid=0, address=0.
- Defaults; write addr 0x3C data 0xA (previous op read, so 1 TURN cycle) -> TURN cycle 1, cs=0 cycles 2-5, we=0 cycles 3-4, data=0xA cycles 2-5, beat=1 cycle 5, ready=1 cycle 6.
- Read 0x3C after that write, model returns 0xA -> TURN cycle 1, oe=0 cycles 3-4, rvalid=1 rdata=0xA cycle 5, data never driven by controller.
- Two back-to-back reads 0x10, 0x11 -> no TURN, second SETUP immediately after first ready cycle, 5 cycles per read.
- Reset low during ACCESS of a write -> same cycle cs=we=1, data Z; after release ready=1, no beat pulse.
- SRAM_CTRL_BURST_EN, write burst_len=3 at 0xFE, data 1,2,3,4 -> addresses FE,FF,00,01 each written with 1,2,3,4, four beat pulses, cs low continuously from SETUP to last HOLD.
